// File: rtl/sevenseg_595_driver.sv
// Renders a 32-bit word as eight hex digits on a daisy chain of eight 74HC595s:
// encode nibbles, shift 64 bits MSB-first on SRCLK, then pulse RCLK once.
module sevenseg_595_driver #(
    parameter int CLK_DIV        = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        sr_ser_o,
    output logic        sr_srclk_o,
    output logic        sr_rclk_o,
    output logic        sr_oe_n_o
);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [6:0]  bit_q, bit_d;
    logic [63:0] frame_q, frame_d;
    logic [31:0] data_q, data_d;
    logic        ser_q, ser_d;
    logic        dv_q, dv_d;
    logic [63:0] frame_enc;
    logic        div_end;

    function automatic logic [7:0] seg_enc(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F;
            4'h1: s = 8'h06;
            4'h2: s = 8'h5B;
            4'h3: s = 8'h4F;
            4'h4: s = 8'h66;
            4'h5: s = 8'h6D;
            4'h6: s = 8'h7D;
            4'h7: s = 8'h07;
            4'h8: s = 8'h7F;
            4'h9: s = 8'h6F;
            4'hA: s = 8'h77;
            4'hB: s = 8'h7C;
            4'hC: s = 8'h39;
            4'hD: s = 8'h5E;
            4'hE: s = 8'h79;
            default: s = 8'h71;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    // Digit i (nibble i) lands in byte i; byte7 is shifted out first.
    always_comb begin
        frame_enc = '0;
        for (int i = 0; i < 8; i++) begin
            frame_enc[i*8 +: 8] = seg_enc(data_q[i*4 +: 4]);
        end
    end

    assign div_end  = (div_q == DIV_LAST);
    assign sr_ser_o = ser_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            frame_q <= '0;
            data_q  <= '0;
            ser_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            ser_q   <= ser_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        frame_d    = frame_q;
        data_d     = data_q;
        ser_d      = ser_q;
        dv_d       = dv_q;
        ready_o    = 1'b0;
        busy_o     = 1'b1;
        done_o     = 1'b0;
        sr_srclk_o = 1'b0;
        sr_rclk_o  = 1'b0;
        sr_oe_n_o  = !dv_q;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                if (valid_i) begin
                    data_d  = data_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                frame_d = frame_enc;
                ser_d   = frame_enc[63];
                bit_d   = '0;
                div_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                sr_srclk_o = 1'b1;
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == 7'd63) begin
                        state_d = LATCH;
                    end else begin
                        // New bit appears together with the SRCLK fall.
                        frame_d = {frame_q[62:0], 1'b0};
                        ser_d   = frame_q[62];
                        bit_d   = bit_q + 7'd1;
                        state_d = SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            LATCH: begin
                sr_rclk_o = 1'b1;
                if (div_end) begin
                    div_d   = '0;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                sr_oe_n_o = 1'b0;
                dv_d      = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/sevenseg_595_driver.md
# sevenseg_595_driver

Downstream display stage for the SPI master. It takes a 32-bit word (Flash or MPU6000 read data) from the controller and renders it as eight hex digits. It encodes each nibble to a 7-segment byte and shifts 64 bits serially into a daisy chain of eight 74HC595 registers. It then pulses the storage latch so all digits update at once.

## Interface
- CLK_DIV, 4: SRCLK half-period in clk_i cycles; legal range 1..255.
- SEG_ACTIVE_LOW, 1: 1 means segment bytes are inverted (common-anode); 0 means active-high.
- clk_i  in  1  system clock; every register is on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- data_i  in  32  word to display; data_i[31:28] goes to digit 7 (leftmost), data_i[3:0] goes to digit 0.
- valid_i  in  1  data_i is offered.
- ready_o  out  1  block can accept a word.
- busy_o  out  1  a frame is in progress (all states except IDLE).
- done_o  out  1  one-cycle pulse when a frame has been latched.
- sr_ser_o  out  1  serial data to the first 74HC595 (SER).
- sr_srclk_o  out  1  shift clock (SRCLK), idles low.
- sr_rclk_o  out  1  storage/latch clock (RCLK), idles low.
- sr_oe_n_o  out  1  output enable (active-low) for the 595 chain.

## Operation
- **Handshake.** A word is accepted when valid_i and ready_o are both high. data_i is captured into a 32-bit holding register. Later changes on data_i have no effect on the current frame.
- **Encoding.**
  - Byte bits 0..6 map to segments a..g. Bit 7 is dp and is always off.
  - Hex table, active-high form: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - When SEG_ACTIVE_LOW=1, the whole byte is inverted, including dp. Example: 0 becomes C0.
- **Frame.** The frame is a 64-bit shift register, {byte7, byte6, ..., byte0}. Bits are shifted MSB-first, so byte7 bit 7 goes first. After 64 shifts, byte0 sits in the 595 nearest SER and byte7 is at the far end of the chain.
- **Counters.**
  - bit counter: 7 bits, counts 0..63.
  - divider counter: 8 bits, counts 0..CLK_DIV-1.
- **State machine.**
  - IDLE: ready_o=1. On handshake, go to LOAD.
  - LOAD (1 cycle): encode and load the 64-bit frame; sr_ser_o <= frame[63]; clear the bit counter. Go to SHIFT_LO.
  - SHIFT_LO (CLK_DIV cycles): sr_srclk_o=0. Go to SHIFT_HI.
  - SHIFT_HI (CLK_DIV cycles): sr_srclk_o=1.
    - At exit, if bit counter=63, go to LATCH.
    - Otherwise shift the frame left, present the next bit on sr_ser_o, increment the bit counter, and go to SHIFT_LO.
  - LATCH (CLK_DIV cycles): sr_srclk_o=0, sr_rclk_o=1. Go to DONE.
  - DONE (1 cycle): sr_rclk_o=0, done_o=1. Set the display-valid flag. Go to IDLE.
- **Output enable.** sr_oe_n_o = !display_valid. This keeps the display blank after reset until the first complete frame is latched.
- **Busy behaviour.** While busy_o=1, ready_o=0 and valid_i is ignored. Nothing is queued.
- **Back-to-back.** If valid_i is held high, the next word is accepted in the first IDLE cycle after DONE.
- **Reset mid-frame.** All outputs return to their reset values within one cycle and the state returns to IDLE. RCLK is never pulsed, so the 595 storage registers keep their previous content, but the display is blanked via sr_oe_n_o.

## Timing
- **Reset values:**
  - ready_o=1; busy_o=0; done_o=0.
  - sr_ser_o=0; sr_srclk_o=0; sr_rclk_o=0; sr_oe_n_o=1.
  - state=IDLE; display_valid=0.
- **Latency.** With the handshake in cycle T, done_o is high in cycle T+2+129*CLK_DIV. For CLK_DIV=2 that is T+260. ready_o is high again in the following cycle.
- **SER setup and hold.**
  - sr_ser_o changes only in the LOAD cycle or in the cycle where SRCLK falls.
  - Setup to each SRCLK rising edge is at least CLK_DIV cycles; hold is CLK_DIV cycles.
- **Pulse counts per frame.** Exactly 64 SRCLK rising edges, then exactly one RCLK pulse of CLK_DIV cycles. RCLK never overlaps SRCLK high.

## Test plan
1. **Reset.** Assert rst_i for 3 cycles with valid_i=1 → all outputs at their reset values, ready_o=1, no SRCLK edges.
2. **Basic frame.** CLK_DIV=2, SEG_ACTIVE_LOW=1, data_i=0x0123_4567. A bench 595-chain model captures on SRCLK rise and latches on RCLK → latched bytes from digit 7 to digit 0 are C0 F9 A4 B0 99 92 82 F8. done_o pulses at T+260; sr_oe_n_o falls in the same cycle and stays low.
3. **Active-high, fastest divider.** SEG_ACTIVE_LOW=0, CLK_DIV=1, data_i=0x89AB_CDEF → latched bytes 7F 6F 77 7C 39 5E 79 71; done_o at T+131; 64 SRCLK rises and 1 RCLK pulse counted.
4. **Back-to-back and input stability.** valid_i held high with 0xFFFF_FFFF then 0x0000_0000, and data_i toggled during shifting → two frames; the first latches all F (8E when active-low); the second is accepted in the cycle after DONE; mid-frame changes on data_i have no effect.
5. **Reset mid-frame.** After one good frame, start 0x1111_1111 and assert rst_i after the 20th SRCLK rise → no RCLK pulse; model storage still shows the old frame; sr_oe_n_o=1; the next frame completes normally.
6. **Busy ignore.** Pulse valid_i once while busy_o=1 → ignored; exactly one done_o pulse; ready_o stays 0 until DONE+1.
